// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell walked LSB-first over WIDTH cycles,
// with operand and result valid/ready handshakes around it.
//
// state | meaning
// IDLE  | waiting for operands; previous result retained on diff/bout
// RUN   | one bit per enabled cycle; en low freezes all datapath state
// DONE  | result presented until the consumer takes it
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             en,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, diff_r;
  logic [CW-1:0]    cnt;
  logic             br, bout_r;
  logic             accept, step, last_bit;
  logic             x, y, d, br_nxt;

  assign x      = a_sh[0];
  assign y      = b_sh[0];
  assign d      = x ^ y ^ br;
  assign br_nxt = (~x & y) | (br & ~(x ^ y));

  // in_ready is masked by rst so the producer never sees a handshake during reset
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign diff      = diff_r;
  assign bout      = bout_r;

  assign accept   = (state == IDLE) && in_valid;
  assign step     = (state == RUN) && en;
  assign last_bit = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (en && last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      diff_r <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_r <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      br     <= bin;
      cnt    <= '0;
      diff_r <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      // concatenate-then-shift keeps WIDTH=1 legal (no reversed part-select)
      diff_r <= WIDTH'({d, diff_r} >> 1);
      br     <= br_nxt;
      if (last_bit) bout_r <= br_nxt;
      else          cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8): latency, stall, backpressure and reset cases
// with hand-computed differences.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       en = 1'b1;
  logic       busy;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] diff;
  logic       bout;

  int checks = 0;
  int failures = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .en(en),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts edges until out_valid, starting from n0 edges already elapsed since accept
  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // drive operands and take the accept edge; returns #1 after that edge with in_valid dropped
  task automatic accept_op(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] ed, input logic eb);
    int n;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    accept_op(av, bv, bi);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(0, n);
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
    tick();
    check({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
    check({tag, "_retained"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int n;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    do_op("basic",  8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
    do_op("under",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    do_op("bin80",  8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    do_op("allone", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // en low for 3 cycles starting at RUN cycle 3
    accept_op(8'h5A, 8'h23, 1'b0);
    tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_busy", 32'(busy), 32'd1);
    end
    en = 1'b1;
    wait_valid(5, n);
    check("stall_latency", 32'(n), 32'd11);
    check("stall_diff", 32'(diff), 32'h37);
    check("stall_bout", 32'(bout), 32'd0);
    tick();

    // backpressure in DONE with new operands waiting
    out_ready = 1'b0;
    accept_op(8'h00, 8'h01, 1'b0);
    wait_valid(0, n);
    a = 8'h80; b = 8'h7F; bin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_diff", 32'(diff), 32'hFF);
      check("bp_bout", 32'(bout), 32'd1);
      tick();
    end
    check("bp_not_taken", 32'(busy), 32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_diff_kept", 32'(diff), 32'hFF);
    tick();
    in_valid = 1'b0;
    check("bp_new_accepted", 32'(busy), 32'd1);
    wait_valid(0, n);
    check("bp_latency", 32'(n), 32'd8);
    check("bp_diff_new", 32'(diff), 32'h00);
    check("bp_bout_new", 32'(bout), 32'd0);
    tick();

    // reset pulse at RUN cycle 4 discards the in-flight subtraction
    accept_op(8'hFF, 8'hFF, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    do_op("after_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
